decoder_strobe: RTL

- Inverse of the team's 8:3 priority encoder. Accepts a binary select code over a valid/ready handshake.
- Drives the matching one-hot line of an OUT_W-bit strobe bus for PULSE_LEN cycles, then forces one all-zero gap cycle.
- Used to fire per-channel enables and IRQ acknowledgements from a compact index. Strobes of consecutive requests never overlap.

---
 rtl/decoder_strobe_pkg.sv | 23 ++
 rtl/decoder_strobe_dec_onehot.sv | 26 ++
 rtl/decoder_strobe.sv | 114 +++++++++++
 3 files changed

// File: rtl/decoder_strobe_pkg.sv
// Shared definitions for the one-hot strobe decoder: FSM encoding,
// default parameter values and a width helper for the pulse counter.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam int DEF_SEL_W     = 3;
   localparam int DEF_OUT_W     = 8;
   localparam int DEF_PULSE_LEN = 4;

   // Smallest r with 2**r >= value; used to size the pulse counter.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/decoder_strobe_dec_onehot.sv
// Combinational binary-to-one-hot converter. Codes that do not map onto
// one of the OUT_W lines give an all-zero vector and a low vld flag.
module dec_onehot
   import decoder_pkg::*;
#(
   parameter int SEL_W = DEF_SEL_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic [SEL_W-1:0] code,
   output logic [OUT_W-1:0] onehot,
   output logic             vld
);

   // Compare the code against every line index; at most one can match.
   always_comb begin
      onehot = '0;
      vld    = 1'b0;
      for (int i = 0; i < OUT_W; i++) begin
         if (code == SEL_W'(i)) begin
            onehot[i] = 1'b1;
            vld       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decoder_strobe.sv
// Strobe decoder: accepts a select code over valid/ready, holds the matching
// one-hot line for PULSE_LEN cycles, then emits one all-zero GAP cycle with
// a done pulse. Out-of-range codes skip the strobe and flag err in the GAP.
module decoder_strobe
   import decoder_pkg::*;
#(
   parameter int SEL_W     = DEF_SEL_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int PULSE_LEN = DEF_PULSE_LEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_code,
   output logic [OUT_W-1:0] out_onehot,
   output logic             out_active,
   output logic             done,
   output logic             err
);

   localparam int CNT_W = clog2(PULSE_LEN + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OUT_W-1:0]   out_onehot_q, out_onehot_d;
   logic               out_active_q, out_active_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [OUT_W-1:0]   dec_onehot_w;
   logic               dec_vld_w;

   dec_onehot #(
      .SEL_W (SEL_W),
      .OUT_W (OUT_W)
   ) u_dec (
      .code   (in_code),
      .onehot (dec_onehot_w),
      .vld    (dec_vld_w)
   );

   // Ready is decoded from state only, so it never depends on in_valid.
   assign in_ready   = (state_q == IDLE);
   assign out_onehot = out_onehot_q;
   assign out_active = out_active_q;
   assign done       = done_q;
   assign err        = err_q;

   // Next-state and next-output logic; outputs are computed for the state
   // being entered so every output leaves the block straight from a flop.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      out_onehot_d = out_onehot_q;
      out_active_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (dec_vld_w) begin
                  state_d      = DRIVE;
                  cnt_d        = CNT_W'(PULSE_LEN - 1);
                  out_onehot_d = dec_onehot_w;
                  out_active_d = 1'b1;
               end else begin
                  state_d      = GAP;
                  out_onehot_d = '0;
                  done_d       = 1'b1;
                  err_d        = 1'b1;
               end
            end
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               state_d      = GAP;
               out_onehot_d = '0;
               done_d       = 1'b1;
            end else begin
               cnt_d        = cnt_q - CNT_W'(1);
               out_active_d = 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d      = IDLE;
            out_onehot_d = '0;
         end
      endcase
   end

   // State, counter and registered outputs; reset clears a strobe at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         out_onehot_q <= '0;
         out_active_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_onehot_q <= out_onehot_d;
         out_active_q <= out_active_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

endmodule
